// File: rtl/rbm_hidden_accumulator.sv
// Pre-activation sum for one RBM hidden unit: bias plus the weights of active visible inputs.
// Streams one weight per cycle from a synchronous-read memory and saturates to signed Q7.4.
module rbm_hidden_accumulator #(
    parameter int unsigned NUM_VISIBLE = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned WEIGHT_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NUM_VISIBLE-1:0] visible_i,
    input  logic [WEIGHT_W-1:0]    bias_i,
    output logic [IDX_W-1:0]       weight_addr_o,
    input  logic [WEIGHT_W-1:0]    weight_data_i,
    output logic                   busy_o,
    output logic [11:0]            sum_o,
    output logic                   valid_o
);

    localparam int unsigned ACC_W = WEIGHT_W + IDX_W + 1;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned SUM_W = 12;
    localparam int unsigned CMP_W = (ACC_W > SUM_W) ? ACC_W : SUM_W;

    localparam logic [IDX_W-1:0]        LAST_ADDR = IDX_W'(NUM_VISIBLE - 1);
    localparam logic [CNT_W-1:0]        LAST_CNT  = CNT_W'(NUM_VISIBLE);
    localparam logic signed [CMP_W-1:0] SAT_MAX   = CMP_W'(2047);
    localparam logic signed [CMP_W-1:0] SAT_MIN   = CMP_W'(-2048);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SAT   = 2'd2
    } state_e;

    state_e                   state_q;
    logic [NUM_VISIBLE-1:0]   vis_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [IDX_W-1:0]         weight_addr_q;
    logic                     busy_q;
    logic                     valid_q;
    logic [SUM_W-1:0]         sum_q;

    logic signed [CMP_W-1:0]  acc_ext_c;
    logic [SUM_W-1:0]         sat_sum_c;

    // Clamp the accumulator into the 12-bit signed result range.
    always_comb begin
        acc_ext_c = CMP_W'(acc_q);
        sat_sum_c = SUM_W'(acc_ext_c);
        if (acc_ext_c > SAT_MAX) begin
            sat_sum_c = 12'h7FF;
        end else if (acc_ext_c < SAT_MIN) begin
            sat_sum_c = 12'h800;
        end
    end

    // cnt_q counts issue cycles; from count 1 on, the datum for the previous address is present.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            vis_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            weight_addr_q <= '0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            sum_q         <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        vis_q         <= visible_i;
                        acc_q         <= ACC_W'($signed(bias_i));
                        cnt_q         <= '0;
                        weight_addr_q <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cnt_q != '0) begin
                        if (vis_q[0]) begin
                            acc_q <= acc_q + ACC_W'($signed(weight_data_i));
                        end
                        vis_q <= vis_q >> 1;
                    end
                    if (weight_addr_q != LAST_ADDR) begin
                        weight_addr_q <= weight_addr_q + IDX_W'(1);
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_SAT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SAT: begin
                    sum_q   <= sat_sum_c;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign weight_addr_o = weight_addr_q;
    assign busy_o        = busy_q;
    assign sum_o         = sum_q;
    assign valid_o       = valid_q;

endmodule

// File: tb/tb_rbm_hidden_accumulator.sv
// Bench for rbm_hidden_accumulator: directed and random runs against an arithmetic reference,
// with a synchronous-read weight memory model.
module tb_rbm_hidden_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] visible;
    logic [7:0]  bias;
    logic [3:0]  weight_addr;
    logic [7:0]  weight_data;
    logic        busy;
    logic [11:0] sum;
    logic        valid;

    logic [7:0]  mem [16];
    logic [11:0] last_sum;
    int          checks;
    int          failures;

    rbm_hidden_accumulator #(
        .NUM_VISIBLE(16),
        .IDX_W      (4),
        .WEIGHT_W   (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .visible_i    (visible),
        .bias_i       (bias),
        .weight_addr_o(weight_addr),
        .weight_data_i(weight_data),
        .busy_o       (busy),
        .sum_o        (sum),
        .valid_o      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) weight_data <= mem[weight_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_sum(input logic [15:0] vis, input logic [7:0] b);
        int acc;
        acc = $signed(b);
        for (int i = 0; i < 16; i++) begin
            if (vis[i]) acc += $signed(mem[i]);
        end
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
        return 12'(acc);
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    endtask

    task automatic issue_start(input logic [15:0] vis, input logic [7:0] b);
        @(negedge clk);
        visible = vis;
        bias    = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Entered in cycle 1 of a run; returns in the valid cycle (19), or after an injected reset.
    // mode 1: disturb visible/bias at cycle 3; mode 2: start pulses at 2 and 10; mode 3: reset at 8.
    task automatic wait_result(input logic [11:0] exp, input logic [11:0] held, input int mode);
        for (int c = 1; c <= 19; c++) begin
            if (mode == 1 && c == 3) begin
                visible = 16'hFFFF;
                bias    = 8'($urandom);
            end
            if (mode == 2) start = (c == 2 || c == 10);
            if (mode == 3 && c == 8) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_valid", 32'(valid), 32'd0);
                chk("abort_sum", 32'(sum), 32'd0);
                chk("abort_addr", 32'(weight_addr), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 25; k++) begin
                    @(negedge clk);
                    chk($sformatf("post_abort_valid@%0d", k), 32'(valid), 32'd0);
                    chk($sformatf("post_abort_busy@%0d", k), 32'(busy), 32'd0);
                end
                return;
            end
            if (c <= 16) chk($sformatf("addr@%0d", c), 32'(weight_addr), 32'(c - 1));
            if (c == 17) chk("addr_hold@17", 32'(weight_addr), 32'd15);
            if (c < 19) begin
                chk($sformatf("busy@%0d", c), 32'(busy), 32'd1);
                chk($sformatf("valid_low@%0d", c), 32'(valid), 32'd0);
                chk($sformatf("sum_held@%0d", c), 32'(sum), 32'(held));
                @(negedge clk);
            end else begin
                chk("valid@19", 32'(valid), 32'd1);
                chk("busy_low@19", 32'(busy), 32'd0);
                chk("sum@19", 32'(sum), 32'(exp));
            end
        end
        start = 1'b0;
    endtask

    task automatic run(input logic [15:0] vis, input logic [7:0] b, input int mode);
        logic [11:0] exp;
        exp = ref_sum(vis, b);
        issue_start(vis, b);
        wait_result(exp, last_sum, mode);
        if (mode == 3) begin
            last_sum = 12'h000;
            return;
        end
        last_sum = exp;
        @(negedge clk);
        chk("valid_pulse_end", 32'(valid), 32'd0);
        chk("sum_after", 32'(sum), 32'(last_sum));
    endtask

    // Second start raised during the first run's valid cycle.
    task automatic run_back_to_back(input logic [15:0] v1, input logic [7:0] b1,
                                    input logic [15:0] v2, input logic [7:0] b2);
        logic [11:0] e1;
        logic [11:0] e2;
        e1 = ref_sum(v1, b1);
        e2 = ref_sum(v2, b2);
        issue_start(v1, b1);
        wait_result(e1, last_sum, 0);
        visible = v2;
        bias    = b2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("b2b_valid_low", 32'(valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_sum_held", 32'(sum), 32'(e1));
        wait_result(e2, e1, 0);
        last_sum = e2;
        @(negedge clk);
        chk("b2b_valid_end", 32'(valid), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_sum = 12'h000;
        rst      = 1'b1;
        start    = 1'b0;
        visible  = 16'h0000;
        bias     = 8'h00;
        fill_const(8'h00);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_addr", 32'(weight_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // No active inputs, zero bias.
        fill_random();
        run(16'h0000, 8'h00, 0);
        chk("case1_sum", 32'(last_sum), 32'h000);

        // Single active weight plus bias.
        fill_const(8'h7F);
        mem[0] = 8'h20;
        run(16'h0001, 8'h10, 0);

        // Positive and negative saturation.
        fill_const(8'h7F);
        run(16'hFFFF, 8'h7F, 0);
        fill_const(8'h80);
        run(16'hFFFF, 8'h80, 0);

        // Alternating inputs with inputs disturbed mid-run.
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        run(16'hAAAA, 8'hF0, 1);

        // Starts while busy are ignored; start in the valid cycle is accepted.
        fill_const(8'h7F);
        mem[0] = 8'h20;
        run(16'h0001, 8'h10, 2);
        fill_random();
        run_back_to_back(16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom));

        // Mid-run reset, then a clean run.
        fill_random();
        run(16'hFFFF, 8'h33, 3);
        chk("post_reset_sum", 32'(sum), 32'd0);
        fill_const(8'h7F);
        mem[0] = 8'h20;
        run(16'h0001, 8'h10, 0);

        // Randomized runs, some with large weights to reach saturation.
        for (int r = 0; r < 10; r++) begin
            if (r % 3 == 0) fill_const(8'($urandom_range(8'h60, 8'hA0)));
            else fill_random();
            run(16'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rbm_hidden_accumulator.md
Name: rbm_hidden_accumulator

Overview:
- Computes the pre-activation sum for one RBM hidden unit: bias plus the sum of weights whose binary visible input is 1.
- Sequential, one weight per cycle, read from a synchronous weight memory.
- The 12-bit saturated result feeds the sigmoid stage's 12-bit sum input directly.
- Fixed-point format is signed Q7.4 (sum value 80 = 5.0), matching the sigmoid breakpoints. Weights and bias are signed Q3.4.

Parameters:
- NUM_VISIBLE, 16, number of visible units and weights per hidden unit (range 2..64).
- IDX_W, 4, weight address width; must satisfy 2^IDX_W >= NUM_VISIBLE.
- WEIGHT_W, 8, signed weight and bias width, Q3.4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request a new accumulation; sampled only in IDLE.
- visible  in  NUM_VISIBLE  binary visible states; captured on the start edge.
- bias  in  WEIGHT_W  signed hidden bias; captured on the start edge.
- weight_addr  out  IDX_W  weight memory read address.
- weight_data  in  WEIGHT_W  signed weight; valid one cycle after weight_addr is presented (synchronous-read RAM).
- busy  out  1  high while an accumulation is in progress.
- sum  out  12  signed Q7.4 saturated result; held until the next result.
- valid  out  1  one-cycle pulse when sum updates.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, busy=0, valid=0, sum=0, weight_addr=0, accumulator=0, index counter=0, captured visible=0.
- Internal accumulator is signed, WEIGHT_W+IDX_W+1 bits (13 at defaults). No overflow is possible inside it.
- States:
  - IDLE: busy=0. When start=1, capture visible and bias; load acc with sign-extended bias; set weight_addr=0; go to ISSUE.
  - ISSUE: busy=1. weight_addr advances by 1 each cycle. Data for index i arrives the cycle after address i is presented. Each cycle with pending data for index i adds sign-extended weight_data to acc when visible_cap[i]=1; otherwise acc holds.
    - Every index is visited regardless of visible bits, so latency is fixed.
    - After address NUM_VISIBLE-1 is issued, one more cycle absorbs the final datum, then go to SAT.
    - weight_addr holds at NUM_VISIBLE-1 in that final cycle. It never exceeds NUM_VISIBLE-1.
  - SAT: busy=1. sum <= clamp(acc, -2048, +2047); valid <= 1; go to IDLE.
- Timing, with the start edge ending cycle 0:
  - address i is driven in cycle i+1 and its weight is added at the edge ending cycle i+2;
  - sum and valid are registered at the edge ending cycle NUM_VISIBLE+2;
  - valid is high, and busy low, during cycle NUM_VISIBLE+3.
  - Start-to-valid latency is NUM_VISIBLE+3 edges (19 at defaults).
- valid is high for exactly one cycle. sum is stable at all other times until the next SAT.
- start while busy=1 is ignored; it is not queued.
- start during the valid cycle is accepted, since the state is IDLE. The new run does not disturb the sum just presented until its own SAT.
- Changes to visible or bias after the start edge have no effect on the current run.
- Saturation: acc > 2047 gives 12'h7FF; acc < -2048 gives 12'h800. Otherwise sum is the low 12 bits of acc.
- Reset asserted mid-run aborts immediately to reset values. No valid is produced for the aborted run.

Test Plan:
1. bias=0, visible=16'h0000, any weights, start -> valid exactly 19 cycles after the start edge, sum=12'h000; weight_addr steps 0..15 anyway.
2. bias=8'h10 (1.0), visible=16'h0001, w[0]=8'h20 (2.0), other weights 8'h7F -> sum=12'h030 (3.0).
3. bias=8'h7F, visible=16'hFFFF, all weights 8'h7F (sum 2159) -> sum=12'h7FF; bias=8'h80, all weights 8'h80 (-2176) -> sum=12'h800.
4. visible=16'hAAAA, w[i]=i (0..15), bias=8'hF0 (-16) -> sum = 1+3+5+7+9+11+13+15-16 = 48 = 12'h030; change visible to 16'hFFFF at cycle 3 -> result unchanged.
5. Pulse start at cycles 2 and 10 of a run -> ignored, single valid. Assert start in the valid cycle -> second run accepted, second valid 19 cycles later with correct sum; first sum stable in between.
6. Assert rst at cycle 8 of a run -> busy=0, valid=0, sum=0, weight_addr=0 immediately, no valid pulse follows. Release and start with case-2 stimulus -> sum=12'h030 at cycle 19.
